recorder_ctrl_fsm: RTL and testbench

- Transport controller for the sound recorder. Turns the PLAY/REC/STOP push-buttons into the 2-bit recorder state consumed by the alphabet display stage.
- Encodes that state as STOP=2'b00, REC=2'b10, PLAY=2'b11.
- Generates sample-memory write/read strobes and addresses, paced by the audio sample tick.
- Tracks the recorded length so that playback stops at the end of the take.

---
 rtl/recorder_ctrl_fsm_if.sv | 12 +
 rtl/recorder_ctrl_fsm.sv | 146 ++++++++++++++
 tb/tb_recorder_ctrl_fsm.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/recorder_ctrl_fsm_if.sv
// Sample-memory bus between the transport controller and the sample RAM.
// The controller drives the bus through the master modport; the RAM observes it through slave.
interface recorder_ctrl_fsm_if #(
  parameter int ADDR_W = 16
) ();
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_re;

  modport master (output mem_addr, output mem_we, output mem_re);
  modport slave  (input  mem_addr, input  mem_we, input  mem_re);
endinterface

// File: rtl/recorder_ctrl_fsm.sv
// Transport controller for the sound recorder: turns the PLAY/REC/STOP buttons into the
// recorder state, and paces sample-memory writes and reads with the audio sample tick.
module recorder_ctrl_fsm #(
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_play,
  input  logic                btn_rec,
  input  logic                btn_stop,
  input  logic                sample_tick,
  output logic [1:0]          state,
  recorder_ctrl_fsm_if.master mem,
  output logic [ADDR_W:0]     rec_len,
  output logic                play_done,
  output logic                full
);

  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_REC  = 2'b10,
    ST_PLAY = 2'b11
  } state_t;

  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] PTR_LAST = {1'b0, {ADDR_W{1'b1}}};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              done_q, done_d;
  logic              full_q, full_d;

  logic [2:0] play_sync, rec_sync, stop_sync;
  logic       press_play, press_rec, press_stop;

  // Bit 0 is the metastability flop; a press is the rising edge seen between bits 1 and 2.
  assign press_play = play_sync[1] & ~play_sync[2];
  assign press_rec  = rec_sync[1]  & ~rec_sync[2];
  assign press_stop = stop_sync[1] & ~stop_sync[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      play_sync <= '0;
      rec_sync  <= '0;
      stop_sync <= '0;
      state_q   <= ST_STOP;
      ptr_q     <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      done_q    <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      play_sync <= {play_sync[1:0], btn_play};
      rec_sync  <= {rec_sync[1:0],  btn_rec};
      stop_sync <= {stop_sync[1:0], btn_stop};
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      re_q      <= re_d;
      done_q    <= done_d;
      full_q    <= full_d;
    end
  end

  // Stop outranks record, which outranks play; a button action also pre-empts a same-cycle tick.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    done_d  = 1'b0;
    full_d  = 1'b0;

    case (state_q)
      ST_STOP: begin
        if (press_stop) begin
          state_d = ST_STOP;
        end else if (press_rec) begin
          state_d = ST_REC;
          ptr_d   = '0;
          len_d   = '0;
        end else if (press_play && (len_q != '0)) begin
          state_d = ST_PLAY;
          ptr_d   = '0;
        end
      end

      ST_REC: begin
        if (press_stop) begin
          state_d = ST_STOP;
        end else if (sample_tick) begin
          we_d   = 1'b1;
          addr_d = ptr_q[ADDR_W-1:0];
          ptr_d  = ptr_q + PTR_ONE;
          len_d  = ptr_q + PTR_ONE;
          if (ptr_q == PTR_LAST) begin
            state_d = ST_STOP;
            full_d  = 1'b1;
          end
        end
      end

      ST_PLAY: begin
        if (press_stop) begin
          state_d = ST_STOP;
        end else if (press_rec) begin
          state_d = ST_REC;
          ptr_d   = '0;
          len_d   = '0;
        end else if (sample_tick) begin
          re_d   = 1'b1;
          addr_d = ptr_q[ADDR_W-1:0];
          ptr_d  = ptr_q + PTR_ONE;
          if (ptr_q == (len_q - PTR_ONE)) begin
            state_d = ST_STOP;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_STOP;
        ptr_d   = '0;
      end
    endcase
  end

  assign state        = state_q;
  assign mem.mem_addr = addr_q;
  assign mem.mem_we   = we_q;
  assign mem.mem_re   = re_q;
  assign rec_len      = len_q;
  assign play_done    = done_q;
  assign full         = full_q;

endmodule

// File: tb/tb_recorder_ctrl_fsm.sv
// Self-checking bench for recorder_ctrl_fsm: vector table, directed corner sequences and a
// randomized run, all compared cycle by cycle against a behavioural model of the recorder.
module tb_recorder_ctrl_fsm;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          btn_play, btn_rec, btn_stop, sample_tick;
  logic [1:0]    state;
  logic [AW:0]   rec_len;
  logic          play_done, full;

  recorder_ctrl_fsm_if #(.ADDR_W(AW)) mem_bus ();

  recorder_ctrl_fsm #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_play   (btn_play),
    .btn_rec    (btn_rec),
    .btn_stop   (btn_stop),
    .sample_tick(sample_tick),
    .state      (state),
    .mem        (mem_bus),
    .rec_len    (rec_len),
    .play_done  (play_done),
    .full       (full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode 0 = stopped, 1 = recording, 2 = playing; button histories hold past samples.
  int m_mode, m_ptr, m_len, m_addr;
  bit m_we, m_re, m_done, m_full;
  bit q_play[$], q_rec[$], q_stop[$];

  typedef struct {
    bit       play, rec, stop, tick;
    bit [1:0] st;
    bit       we, re;
    int       addr, len;
    bit       done, fl;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mkVec(bit p, bit r, bit s, bit t, bit [1:0] st, bit we, bit re,
                                 int addr, int len, bit done, bit fl);
    vec_t v;
    v.play = p; v.rec = r; v.stop = s; v.tick = t;
    v.st = st; v.we = we; v.re = re; v.addr = addr; v.len = len; v.done = done; v.fl = fl;
    return v;
  endfunction

  function automatic bit pressed(input bit q[$]);
    return q[1] && !q[2];
  endfunction

  function automatic logic [1:0] modeBits(input int m);
    case (m)
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function void modelReset();
    m_mode = 0; m_ptr = 0; m_len = 0; m_addr = 0;
    m_we = 0; m_re = 0; m_done = 0; m_full = 0;
    q_play = '{0, 0, 0};
    q_rec  = '{0, 0, 0};
    q_stop = '{0, 0, 0};
  endfunction

  function void modelEdge(bit p, bit r, bit s, bit t, bit rs);
    bit pp, pr, ps;
    if (rs) begin
      modelReset();
      return;
    end
    pp = pressed(q_play);
    pr = pressed(q_rec);
    ps = pressed(q_stop);
    m_we = 0; m_re = 0; m_done = 0; m_full = 0;
    if (m_mode == 0) begin
      if (ps) begin
      end else if (pr) begin
        m_mode = 1; m_ptr = 0; m_len = 0;
      end else if (pp && m_len > 0) begin
        m_mode = 2; m_ptr = 0;
      end
    end else if (m_mode == 1) begin
      if (ps) m_mode = 0;
      else if (t) begin
        m_we = 1; m_addr = m_ptr; m_ptr++; m_len = m_ptr;
        if (m_len == DEPTH) begin
          m_mode = 0; m_full = 1;
        end
      end
    end else begin
      if (ps) m_mode = 0;
      else if (pr) begin
        m_mode = 1; m_ptr = 0; m_len = 0;
      end else if (t) begin
        m_re = 1; m_addr = m_ptr; m_ptr++;
        if (m_ptr == m_len) begin
          m_mode = 0; m_done = 1;
        end
      end
    end
    q_play.push_front(p); void'(q_play.pop_back());
    q_rec.push_front(r);  void'(q_rec.pop_back());
    q_stop.push_front(s); void'(q_stop.pop_back());
  endfunction

  task automatic checkField(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkField({tag, "_state"}, int'(state), int'(modeBits(m_mode)));
    checkField({tag, "_addr"}, int'(mem_bus.mem_addr), m_addr);
    checkField({tag, "_we"}, int'(mem_bus.mem_we), int'(m_we));
    checkField({tag, "_re"}, int'(mem_bus.mem_re), int'(m_re));
    checkField({tag, "_len"}, int'(rec_len), m_len);
    checkField({tag, "_done"}, int'(play_done), int'(m_done));
    checkField({tag, "_full"}, int'(full), int'(m_full));
  endtask

  task automatic applyStimulus(input bit p, input bit r, input bit s, input bit t, input bit rs,
                               input string tag);
    btn_play = p; btn_rec = r; btn_stop = s; sample_tick = t; rst = rs;
    @(posedge clk);
    modelEdge(p, r, s, t, rs);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    int bad_st, bad_re, n_we, full_cnt, full_at;
    int wr_addr[DEPTH];
    bit lp, lr, ls;

    btn_play = 0; btn_rec = 0; btn_stop = 0; sample_tick = 0; rst = 1;
    modelReset();

    vecs[0]  = mkVec(0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mkVec(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mkVec(0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mkVec(0, 0, 0, 1, 2'b10, 1, 0, 0, 1, 0, 0);
    vecs[4]  = mkVec(0, 0, 0, 0, 2'b10, 0, 0, 0, 1, 0, 0);
    vecs[5]  = mkVec(0, 0, 0, 1, 2'b10, 1, 0, 1, 2, 0, 0);
    vecs[6]  = mkVec(0, 0, 0, 1, 2'b10, 1, 0, 2, 3, 0, 0);
    vecs[7]  = mkVec(1, 0, 1, 0, 2'b10, 0, 0, 2, 3, 0, 0);
    vecs[8]  = mkVec(0, 0, 0, 0, 2'b10, 0, 0, 2, 3, 0, 0);
    vecs[9]  = mkVec(0, 0, 0, 1, 2'b00, 0, 0, 2, 3, 0, 0);
    vecs[10] = mkVec(1, 0, 0, 0, 2'b00, 0, 0, 2, 3, 0, 0);
    vecs[11] = mkVec(0, 0, 0, 0, 2'b00, 0, 0, 2, 3, 0, 0);
    vecs[12] = mkVec(0, 0, 0, 1, 2'b11, 0, 0, 2, 3, 0, 0);
    vecs[13] = mkVec(0, 0, 0, 1, 2'b11, 0, 1, 0, 3, 0, 0);
    vecs[14] = mkVec(0, 0, 0, 1, 2'b11, 0, 1, 1, 3, 0, 0);
    vecs[15] = mkVec(0, 0, 0, 1, 2'b00, 0, 1, 2, 3, 1, 0);
    vecs[16] = mkVec(0, 0, 0, 1, 2'b00, 0, 0, 2, 3, 0, 0);

    applyStimulus(0, 0, 0, 0, 1, "reset");
    applyStimulus(0, 0, 0, 1, 1, "reset");
    checkField("reset_state", int'(state), 0);
    checkField("reset_len", int'(rec_len), 0);
    checkField("reset_strobes", int'({mem_bus.mem_we, mem_bus.mem_re, play_done, full}), 0);

    // Play with an empty take must leave the recorder stopped.
    bad_st = 0; bad_re = 0;
    applyStimulus(1, 0, 0, 0, 0, "empty_play");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, (i % 3) == 0, 0, "empty_play");
      if (state != 2'b00) bad_st++;
      if (mem_bus.mem_re) bad_re++;
    end
    checkField("empty_play_nonstop_cycles", bad_st, 0);
    checkField("empty_play_reads", bad_re, 0);

    for (int i = 0; i < 17; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].play, vecs[i].rec, vecs[i].stop, vecs[i].tick, 0, tag);
      checkField({tag, "_tbl_state"}, int'(state), int'(vecs[i].st));
      checkField({tag, "_tbl_we"}, int'(mem_bus.mem_we), int'(vecs[i].we));
      checkField({tag, "_tbl_re"}, int'(mem_bus.mem_re), int'(vecs[i].re));
      checkField({tag, "_tbl_addr"}, int'(mem_bus.mem_addr), vecs[i].addr);
      checkField({tag, "_tbl_len"}, int'(rec_len), vecs[i].len);
      checkField({tag, "_tbl_done"}, int'(play_done), int'(vecs[i].done));
      checkField({tag, "_tbl_full"}, int'(full), int'(vecs[i].fl));
    end

    // Record until the memory is exhausted; the ninth tick must be ignored.
    applyStimulus(0, 1, 0, 0, 0, "fill");
    applyStimulus(0, 0, 0, 0, 0, "fill");
    applyStimulus(0, 0, 0, 0, 0, "fill");
    checkField("fill_enter_rec", int'(state), 2);
    n_we = 0; full_cnt = 0; full_at = -1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      applyStimulus(0, 0, 0, 1, 0, "fill");
      if (mem_bus.mem_we) begin
        if (n_we < DEPTH) wr_addr[n_we] = int'(mem_bus.mem_addr);
        n_we++;
      end
      if (full) begin
        full_cnt++;
        full_at = n_we;
      end
      applyStimulus(0, 0, 0, 0, 0, "fill");
    end
    checkField("fill_write_count", n_we, DEPTH);
    checkField("fill_full_count", full_cnt, 1);
    checkField("fill_full_with_last_write", full_at, DEPTH);
    for (int i = 0; i < DEPTH; i++)
      checkField($sformatf("fill_addr%0d", i), wr_addr[i], i);
    checkField("fill_len", int'(rec_len), DEPTH);
    checkField("fill_state", int'(state), 0);

    // Reset in the middle of playback wipes the take.
    applyStimulus(1, 0, 0, 0, 0, "midrst");
    applyStimulus(0, 0, 0, 0, 0, "midrst");
    applyStimulus(0, 0, 0, 0, 0, "midrst");
    checkField("midrst_enter_play", int'(state), 3);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, "midrst");
    checkField("midrst_addr_before", int'(mem_bus.mem_addr), 2);
    applyStimulus(0, 0, 0, 1, 1, "midrst");
    checkField("midrst_state", int'(state), 0);
    checkField("midrst_addr", int'(mem_bus.mem_addr), 0);
    checkField("midrst_len", int'(rec_len), 0);
    checkField("midrst_strobes", int'({mem_bus.mem_we, mem_bus.mem_re}), 0);
    applyStimulus(1, 0, 0, 0, 0, "midrst");
    applyStimulus(0, 0, 0, 1, 0, "midrst");
    applyStimulus(0, 0, 0, 1, 0, "midrst");
    checkField("midrst_play_after", int'(state), 0);

    lp = 0; lr = 0; ls = 0;
    for (int i = 0; i < 4000; i++) begin
      lp = lp ? ($urandom_range(2) != 0) : ($urandom_range(15) == 0);
      lr = lr ? ($urandom_range(2) != 0) : ($urandom_range(25) == 0);
      ls = ls ? ($urandom_range(2) != 0) : ($urandom_range(40) == 0);
      applyStimulus(lp, lr, ls, $urandom_range(2) == 0, $urandom_range(499) == 0, "rand");
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
